// File: rtl/alu_response_checker.sv
// alu_response_checker: receiving end of the ALU stimulus interface.
// It takes (A, B, sel, observed result) samples over a valid/ready handshake.
// For each sample it recomputes the expected WIDTH-bit ALU result, counts
// passes and fails with saturating counters, and latches the first mismatch.
//
// Ports:
//   clk, reset           rising-edge clock, synchronous active-high reset
//   start, finish        run control pulses
//   in_valid/in_ready    sample handshake; in_a, in_b, in_sel, in_out carry the sample
//   pass_cnt, fail_cnt   saturating match/mismatch counters
//   err_flag             sticky first-mismatch flag
//   ff_a, ff_b, ff_sel   first-fail sample fields
//   ff_got, ff_exp       first-fail observed and expected results
//   busy, done, all_pass status
module alu_response_checker #(
  parameter int WIDTH = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             finish,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [1:0]       in_sel,
  input  logic [WIDTH-1:0] in_out,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic             err_flag,
  output logic [WIDTH-1:0] ff_a,
  output logic [WIDTH-1:0] ff_b,
  output logic [1:0]       ff_sel,
  output logic [WIDTH-1:0] ff_got,
  output logic [WIDTH-1:0] ff_exp,
  output logic             busy,
  output logic             done,
  output logic             all_pass
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t           state_q, state_d;
  // Stage 1: accepted sample plus its expected result
  logic             s1_vld_q, s1_vld_d;
  logic [WIDTH-1:0] s1_a_q, s1_a_d, s1_b_q, s1_b_d;
  logic [WIDTH-1:0] s1_got_q, s1_got_d, s1_exp_q, s1_exp_d;
  logic [1:0]       s1_sel_q, s1_sel_d;
  // Stage 2: results
  logic [CNT_W-1:0] pass_q, pass_d, fail_q, fail_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] ffa_q, ffa_d, ffb_q, ffb_d, ffgot_q, ffgot_d, ffexp_q, ffexp_d;
  logic [1:0]       ffsel_q, ffsel_d;

  logic accept, clr_run;

  function automatic logic [WIDTH-1:0] alu_exp(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b,
                                               input logic [1:0]       sel);
    logic [WIDTH-1:0] r;
    case (sel)
      2'b00:   r = a & b;
      2'b01:   r = a | b;
      2'b10:   r = a + b;  // carry drops off the top
      default: r = a - b;  // borrow drops off the top
    endcase
    return r;
  endfunction

  // FSM next state and handshake
  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN: begin
        in_ready = 1'b1;
        if (finish) state_d = S_DRAIN;
      end
      // Stage 1 is empty once the last accepted sample has been compared.
      S_DRAIN: if (!s1_vld_q) state_d = S_DONE;
      default: if (start) state_d = S_RUN;
    endcase
  end

  assign accept  = in_valid & in_ready;
  assign clr_run = start & ((state_q == S_IDLE) | (state_q == S_DONE));

  // Stage 1 capture
  always_comb begin
    s1_vld_d = accept;
    s1_a_d   = s1_a_q;
    s1_b_d   = s1_b_q;
    s1_sel_d = s1_sel_q;
    s1_got_d = s1_got_q;
    s1_exp_d = s1_exp_q;
    if (accept) begin
      s1_a_d   = in_a;
      s1_b_d   = in_b;
      s1_sel_d = in_sel;
      s1_got_d = in_out;
      s1_exp_d = alu_exp(in_a, in_b, in_sel);
    end
  end

  // Stage 2 compare and bookkeeping
  always_comb begin
    pass_d  = pass_q;
    fail_d  = fail_q;
    err_d   = err_q;
    ffa_d   = ffa_q;
    ffb_d   = ffb_q;
    ffsel_d = ffsel_q;
    ffgot_d = ffgot_q;
    ffexp_d = ffexp_q;
    if (clr_run) begin
      // Stage 1 is always empty outside RUN/DRAIN, so nothing is lost here.
      pass_d  = '0;
      fail_d  = '0;
      err_d   = 1'b0;
      ffa_d   = '0;
      ffb_d   = '0;
      ffsel_d = '0;
      ffgot_d = '0;
      ffexp_d = '0;
    end else if (s1_vld_q) begin
      if (s1_got_q == s1_exp_q) begin
        if (pass_q != CNT_MAX) pass_d = pass_q + 1'b1;
      end else begin
        if (fail_q != CNT_MAX) fail_d = fail_q + 1'b1;
        if (!err_q) begin
          err_d   = 1'b1;
          ffa_d   = s1_a_q;
          ffb_d   = s1_b_q;
          ffsel_d = s1_sel_q;
          ffgot_d = s1_got_q;
          ffexp_d = s1_exp_q;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      s1_vld_q <= 1'b0;
      s1_a_q   <= '0;
      s1_b_q   <= '0;
      s1_sel_q <= '0;
      s1_got_q <= '0;
      s1_exp_q <= '0;
      pass_q   <= '0;
      fail_q   <= '0;
      err_q    <= 1'b0;
      ffa_q    <= '0;
      ffb_q    <= '0;
      ffsel_q  <= '0;
      ffgot_q  <= '0;
      ffexp_q  <= '0;
    end else begin
      state_q  <= state_d;
      s1_vld_q <= s1_vld_d;
      s1_a_q   <= s1_a_d;
      s1_b_q   <= s1_b_d;
      s1_sel_q <= s1_sel_d;
      s1_got_q <= s1_got_d;
      s1_exp_q <= s1_exp_d;
      pass_q   <= pass_d;
      fail_q   <= fail_d;
      err_q    <= err_d;
      ffa_q    <= ffa_d;
      ffb_q    <= ffb_d;
      ffsel_q  <= ffsel_d;
      ffgot_q  <= ffgot_d;
      ffexp_q  <= ffexp_d;
    end
  end

  assign pass_cnt = pass_q;
  assign fail_cnt = fail_q;
  assign err_flag = err_q;
  assign ff_a     = ffa_q;
  assign ff_b     = ffb_q;
  assign ff_sel   = ffsel_q;
  assign ff_got   = ffgot_q;
  assign ff_exp   = ffexp_q;
  assign busy     = (state_q == S_RUN) | (state_q == S_DRAIN);
  assign done     = (state_q == S_DONE);
  assign all_pass = done & ~err_q & (pass_q != '0);

endmodule

// File: tb/tb_alu_response_checker.sv
// Directed bench for alu_response_checker. A second instance with CNT_W=3
// shares the stimulus so that counter saturation can be observed.
module tb_alu_response_checker;
  logic clk = 1'b0;
  logic reset, start, finish, in_valid;
  logic [4:0] in_a, in_b, in_out;
  logic [1:0] in_sel;

  logic        in_ready, err_flag, busy, done, all_pass;
  logic [15:0] pass_cnt, fail_cnt;
  logic [4:0]  ff_a, ff_b, ff_got, ff_exp;
  logic [1:0]  ff_sel;

  logic        s_in_ready, s_err_flag, s_busy, s_done, s_all_pass;
  logic [2:0]  s_pass_cnt, s_fail_cnt;
  logic [4:0]  s_ff_a, s_ff_b, s_ff_got, s_ff_exp;
  logic [1:0]  s_ff_sel;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_response_checker #(.WIDTH(5), .CNT_W(16)) u_dut (
    .clk(clk), .reset(reset), .start(start), .finish(finish),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .in_sel(in_sel), .in_out(in_out), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt),
    .err_flag(err_flag), .ff_a(ff_a), .ff_b(ff_b), .ff_sel(ff_sel),
    .ff_got(ff_got), .ff_exp(ff_exp), .busy(busy), .done(done), .all_pass(all_pass)
  );

  alu_response_checker #(.WIDTH(5), .CNT_W(3)) u_sat (
    .clk(clk), .reset(reset), .start(start), .finish(finish),
    .in_valid(in_valid), .in_ready(s_in_ready), .in_a(in_a), .in_b(in_b),
    .in_sel(in_sel), .in_out(in_out), .pass_cnt(s_pass_cnt), .fail_cnt(s_fail_cnt),
    .err_flag(s_err_flag), .ff_a(s_ff_a), .ff_b(s_ff_b), .ff_sel(s_ff_sel),
    .ff_got(s_ff_got), .ff_exp(s_ff_exp), .busy(s_busy), .done(s_done),
    .all_pass(s_all_pass)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic pulse_finish();
    finish = 1'b1; tick(); finish = 1'b0;
  endtask

  task automatic send(input logic [4:0] a, input logic [4:0] b,
                      input logic [1:0] sel, input logic [4:0] o);
    in_valid = 1'b1; in_a = a; in_b = b; in_sel = sel; in_out = o;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; finish = 1'b0; in_valid = 1'b0;
    in_a = '0; in_b = '0; in_sel = '0; in_out = '0;
    tick(); tick();
    reset = 1'b0;
    chk("rst_pass", pass_cnt, 0);
    chk("rst_fail", fail_cnt, 0);
    chk("rst_err", err_flag, 0);
    chk("rst_ready", in_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);

    // in_valid while idle must not be accepted
    send(5'b00001, 5'b00001, 2'b00, 5'b00001);
    tick(); tick();
    chk("idle_ignore", pass_cnt, 0);

    // Baseline: all selects pass
    pulse_start();
    chk("run_ready", in_ready, 1);
    send(5'b10110, 5'b11010, 2'b00, 5'b10010);
    send(5'b10110, 5'b11010, 2'b01, 5'b11110);
    send(5'b10110, 5'b11010, 2'b10, 5'b10000);
    send(5'b10110, 5'b11010, 2'b11, 5'b11100);
    pulse_finish();
    chk("drain_ready", in_ready, 0);
    chk("drain_busy", busy, 1);
    tick();
    chk("base_done", done, 1);
    chk("base_ready", in_ready, 0);
    chk("base_pass", pass_cnt, 4);
    chk("base_fail", fail_cnt, 0);
    chk("base_allpass", all_pass, 1);

    // Mismatch capture, restarting from DONE
    pulse_start();
    chk("restart_clr", pass_cnt, 0);
    chk("restart_ready", in_ready, 1);
    send(5'b10110, 5'b11010, 2'b00, 5'b10010);
    send(5'b10110, 5'b11010, 2'b01, 5'b11110);
    send(5'b10110, 5'b11010, 2'b10, 5'b10110);
    send(5'b10110, 5'b11010, 2'b11, 5'b00000);
    pulse_finish();
    tick();
    chk("mm_done", done, 1);
    chk("mm_fail", fail_cnt, 2);
    chk("mm_pass", pass_cnt, 2);
    chk("mm_err", err_flag, 1);
    chk("mm_ff_a", ff_a, 5'b10110);
    chk("mm_ff_b", ff_b, 5'b11010);
    chk("mm_ff_sel", ff_sel, 2'b10);
    chk("mm_ff_got", ff_got, 5'b10110);
    chk("mm_ff_exp", ff_exp, 5'b10000);
    chk("mm_allpass", all_pass, 0);

    // start during RUN is ignored
    pulse_start();
    chk("clr_err", err_flag, 0);
    chk("clr_ff_got", ff_got, 0);
    send(5'b00011, 5'b00101, 2'b00, 5'b00001);
    pulse_start();
    chk("start_busy_ign", pass_cnt, 1);
    chk("start_busy_run", in_ready, 1);
    pulse_finish();
    tick();
    chk("ign_done", done, 1);

    // Sample offered together with finish
    pulse_start();
    in_valid = 1'b1; in_a = 5'b00001; in_b = 5'b00001; in_sel = 2'b11; in_out = 5'b00000;
    finish = 1'b1;
    tick();
    in_valid = 1'b0; finish = 1'b0;
    chk("simfin_done0", done, 0);
    tick();
    chk("simfin_done1", done, 0);
    chk("simfin_pass", pass_cnt, 1);
    tick();
    chk("simfin_done2", done, 1);
    chk("simfin_allpass", all_pass, 1);

    // Empty run
    pulse_start();
    pulse_finish();
    tick();
    chk("empty_done", done, 1);
    chk("empty_allpass", all_pass, 0);
    chk("empty_pass", pass_cnt, 0);
    // finish outside RUN is ignored
    pulse_finish();
    chk("fin_done_ign", done, 1);

    // Reset mid-run discards the in-flight sample
    pulse_start();
    send(5'b00001, 5'b00010, 2'b01, 5'b00011);
    send(5'b00111, 5'b00001, 2'b10, 5'b01000);
    send(5'b00100, 5'b00110, 2'b11, 5'b11110);
    chk("pre_rst_pass", pass_cnt, 2);
    reset = 1'b1; tick(); reset = 1'b0;
    chk("midrst_pass", pass_cnt, 0);
    chk("midrst_fail", fail_cnt, 0);
    chk("midrst_ready", in_ready, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    tick(); tick();
    chk("midrst_late", pass_cnt, 0);

    // Saturation: 10 passing samples, narrow counter holds at 7
    pulse_start();
    for (int i = 0; i < 10; i++) begin
      logic [4:0] a;
      a = 5'(i);
      send(a, 5'b00011, 2'b10, a + 5'd3);
    end
    pulse_finish();
    tick();
    chk("sat_wide_pass", pass_cnt, 10);
    chk("sat_pass", s_pass_cnt, 7);
    chk("sat_fail", s_fail_cnt, 0);
    chk("sat_done", s_done, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/alu_response_checker.md
Name: alu_response_checker

Overview:
- Receiving/checking end of the ALU stimulus interface. Accepts (operand A, operand B, select, observed result) samples over a valid/ready handshake.
- Recomputes the expected 5-bit ALU result, counts passes and fails, and latches the first mismatch for debug.
- Sits beside the likeALU-style datapath, in place of a console monitor, so runs are self-checking in simulation and on board.

Parameters:
- WIDTH, 5, operand/result width in bits.
- CNT_W, 16, width of pass/fail counters (saturating).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  pulse: clear counters and enter RUN (honoured in IDLE or DONE only)
- finish  input  1  pulse: stop accepting after the current cycle (honoured in RUN only)
- in_valid  input  1  sample present
- in_ready  output  1  checker accepts a sample this cycle
- in_a  input  WIDTH  operand A
- in_b  input  WIDTH  operand B
- in_sel  input  2  ALU select
- in_out  input  WIDTH  observed ALU result
- pass_cnt  output  CNT_W  matching samples
- fail_cnt  output  CNT_W  mismatching samples
- err_flag  output  1  sticky; set on first mismatch
- ff_a, ff_b  output  WIDTH  first-fail operands
- ff_sel  output  2  first-fail select
- ff_got, ff_exp  output  WIDTH  first-fail observed and expected results
- busy  output  1  state is RUN or DRAIN
- done  output  1  state is DONE
- all_pass  output  1  done & ~err_flag & (pass_cnt != 0)

Behaviour:
- Reset (synchronous, active-high, overrides all other inputs):
  - State goes to IDLE.
  - All outputs go to 0, including counters, ff_* and err_flag.
  - Pipeline valid bit is cleared. A reset in the middle of a run discards any in-flight sample.
- Expected result, computed mod 2^WIDTH:
  - sel 00: A & B
  - sel 01: A | B
  - sel 10: A + B, carry discarded
  - sel 11: A - B, two's complement, borrow discarded
- FSM states:
  - IDLE: in_ready = 0. start -> RUN.
  - RUN: in_ready = 1. A sample is accepted when in_valid & in_ready. finish -> DRAIN. A sample offered in the same cycle as finish is still accepted.
  - DRAIN: in_ready = 0. Moves to DONE once the compare stage is empty, i.e. the cycle after entry.
  - DONE: in_ready = 0; counters and ff_* hold. start -> RUN.
- Entering RUN from IDLE or DONE clears pass_cnt, fail_cnt, err_flag and ff_*, all in the same edge.
- Pipeline, 2 stages:
  - Edge 1: register the accepted sample and its expected value.
  - Edge 2: compare, then update counters, err_flag and ff_*.
  - Counter latency from accept to update is 2 clocks. Back-to-back samples are accepted every cycle (throughput 1).
- Counters saturate at 2^CNT_W - 1 and never wrap.
- ff_* capture only when err_flag is 0 at the moment of a mismatch. Later mismatches increment fail_cnt only.
- Ignored events:
  - start while busy: ignored.
  - finish outside RUN: ignored.
  - in_valid outside RUN: ignored; no sample is accepted.
- A run with zero samples reaches DONE with all_pass = 0.

Test Plan:
- Baseline, all selects: reset, start, then 4 samples with A = 10110, B = 11010, sel = 00/01/10/11 and out = 10010/11110/10000/11100, then finish.
  - Required: done = 1, pass_cnt = 4, fail_cnt = 0, all_pass = 1.
  - Required: in_ready = 0 from the DRAIN cycle onward.
- Mismatch capture: same samples, but sel 10 carries out = 10110 and sel 11 carries out = 00000.
  - Required: fail_cnt = 2, pass_cnt = 2, err_flag = 1.
  - Required: ff_sel = 10, ff_got = 10110, ff_exp = 10000. ff_* unchanged by the second failure.
- Simultaneous finish: a valid sample (A = 00001, B = 00001, sel = 11, out = 00000) in the same cycle as finish.
  - Required: the sample is counted, pass_cnt = 1.
  - Required: done is asserted exactly 2 cycles after the finish edge.
- Reset mid-run: 3 samples accepted back-to-back, then reset asserted the cycle after the 3rd accept.
  - Required: all counters 0, state IDLE, in_ready = 0, no late counter update.
- Restart and no-op inputs:
  - start during RUN -> ignored, counters unchanged.
  - start in DONE -> counters clear and in_ready = 1 on the next cycle.
  - Empty run (start then finish) -> done = 1, all_pass = 0.
- Saturation, with CNT_W = 3: feed 10 passing samples.
  - Required: pass_cnt holds at 7 and does not wrap.
